// File: rtl/edsac_delay_line.sv
// Digital stand-in for one EDSAC mercury delay-line tank: a 1-bit pulse stream is
// synchronised, recirculated through a circular RAM ring and replayed DELAY_CYCLES later.
module edsac_delay_line #(
    parameter int CLK_FREQ     = 135_000_000,
    parameter int DELAY_CYCLES = 135_000,
    parameter int SYNC_STAGES  = 2,
    parameter int ADDR_WIDTH   = $clog2(DELAY_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic in,
    output logic out
);

    // The ring absorbs whatever latency the synchroniser, RAM read and output register do not.
    localparam int DEPTH      = DELAY_CYCLES - SYNC_STAGES - 2;
    localparam int FILL_WIDTH = $clog2(DELAY_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(DELAY_CYCLES);
    localparam logic [FILL_WIDTH-1:0] FILL_OPEN = FILL_WIDTH'(DELAY_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [ADDR_WIDTH-1:0]  ptr;
    logic                   ram [0:DEPTH-1];
    logic                   rd_data;
    logic [FILL_WIDTH-1:0]  fill;
    logic                   valid;

    // clk_in shares the clk net and CLK_FREQ is documentation only; neither drives logic.
    logic unused_inputs;
    assign unused_inputs = clk_in ^ (CLK_FREQ == 0);

    // NOTE: every sequential block uses non-blocking assignments so that each flop
    // samples the pre-edge value of its neighbour, which is what makes the chain shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // One pointer serves both read and write: the slot read now was written DEPTH cycles ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ptr == LAST_ADDR) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

    // NOTE: the ring RAM has no reset so it maps onto block RAM; stale contents after
    // reset are hidden by the fill counter and valid flag below instead.
    always_ff @(posedge clk) begin
        rd_data   <= ram[ptr];
        ram[ptr]  <= sync_bit;
    end

    // valid rises one cycle before the first post-reset sample reaches the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill  <= '0;
            valid <= 1'b0;
        end else begin
            if (fill != FILL_FULL) begin
                fill <= fill + FILL_WIDTH'(1);
            end
            if (fill == FILL_OPEN) begin
                valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= valid & rd_data;
        end
    end

endmodule

// File: tb/tb_edsac_delay_line.sv
// Directed bench for edsac_delay_line at a scaled-down delay; every cycle is compared
// against a history model plus per-scenario edge timing and pulse-shape checks.
module tb_edsac_delay_line;

    localparam int DELAY = 40;
    localparam int SYNC  = 2;
    localparam int DEPTH = DELAY - SYNC - 2;
    localparam int HIST  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout;

    int cyc    = 0;
    int r0     = 0;
    int n_vec  = 0;
    int n_miss = 0;

    bit   vh [HIST];
    bit   rh [HIST];
    logic stim [$];
    int   exp_q [$];

    edsac_delay_line #(
        .CLK_FREQ    (135_000_000),
        .DELAY_CYCLES(DELAY),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_in(clk),
        .in    (din),
        .out   (dout)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, record it in the history, then sample #1 after the edge.
    task automatic drive(input logic iv, input logic rv);
        din = iv;
        rst = rv;
        vh[cyc % HIST] = iv;
        rh[cyc % HIST] = rv;
        if (!rv && (cyc == 0 || rh[(cyc - 1) % HIST])) r0 = cyc;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Expected out after the latest edge: zero in reset or during the refill window,
    // otherwise the value that was driven DELAY cycles earlier.
    function automatic logic model_out();
        if (rh[(cyc - 1) % HIST]) return 1'b0;
        if (cyc - r0 < DELAY) return 1'b0;
        return vh[(cyc - DELAY) % HIST];
    endfunction

    task automatic push_digit(input logic b);
        for (int p = 0; p < 12; p++) begin
            repeat (5) stim.push_back(b);
            repeat (5) stim.push_back(1'b0);
        end
    endtask

    task automatic push_idle(input int n);
        repeat (n) stim.push_back(1'b0);
    endtask

    task automatic test_reset;
        logic want;
        repeat (5) drive(1'b0, 1'b1);
        n_vec++;
        if (dout !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_out: out=%b expected 0", dout);
        end
        for (int i = 0; i < 2 * DELAY; i++) begin
            drive(1'b0, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL idle_low cycle %0d: out=%b expected %b", cyc, dout, want);
            end
        end
    endtask

    task automatic test_const_high;
        int k0;
        int first_high;
        int low_after;
        logic want;
        k0 = cyc;
        first_high = -1;
        low_after = 0;
        for (int i = 0; i < 3 * DELAY; i++) begin
            drive(1'b1, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL const_high cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && first_high < 0) first_high = cyc;
            if (first_high >= 0 && dout !== 1'b1) low_after++;
        end
        n_vec++;
        if (first_high != k0 + DELAY || low_after != 0) begin
            n_miss++;
            $display("FAIL const_high_rise: rose at %0d with %0d drops, expected %0d with 0",
                     first_high, low_after, k0 + DELAY);
        end
        for (int i = 0; i < DELAY + 5; i++) begin
            drive(1'b0, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL const_high_tail cycle %0d: out=%b expected %b", cyc, dout, want);
            end
        end
    endtask

    // Fill the ring with ones, reset, then feed zeros: nothing stale may leak out.
    task automatic test_stale;
        int highs;
        logic want;
        highs = 0;
        repeat (DELAY) drive(1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b1);
        for (int i = 0; i < DELAY + 5; i++) begin
            drive(1'b0, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL stale cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1) highs++;
        end
        n_vec++;
        if (highs != 0) begin
            n_miss++;
            $display("FAIL stale_count: %0d high cycles, expected 0", highs);
        end
    endtask

    task automatic test_single_pulse;
        int k0, rise_at, rises, width;
        logic prev_out, want;
        stim.delete();
        repeat (5) stim.push_back(1'b1);
        push_idle(DELAY + 10);
        k0 = cyc;
        rise_at = -1;
        rises = 0;
        width = 0;
        prev_out = dout;
        for (int i = 0; i < stim.size(); i++) begin
            drive(stim[i], 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL pulse cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && prev_out !== 1'b1) begin
                rises++;
                if (rise_at < 0) rise_at = cyc;
            end
            if (dout === 1'b1) width++;
            prev_out = dout;
        end
        n_vec++;
        if (rise_at != k0 + DELAY || rises != 1 || width != 5) begin
            n_miss++;
            $display("FAIL pulse_shape: rise %0d rises %0d width %0d, expected %0d 1 5",
                     rise_at, rises, width, k0 + DELAY);
        end
    endtask

    task automatic test_word;
        int rises;
        logic prev_in, prev_out, want;
        stim.delete();
        exp_q.delete();
        for (int d = 0; d < 35; d++) push_digit(1'b1);
        push_digit(1'b0);
        push_idle(135);
        push_idle(DELAY + 10);
        rises = 0;
        prev_in = 1'b0;
        prev_out = dout;
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i] && !prev_in) exp_q.push_back(cyc + DELAY);
            prev_in = stim[i];
            drive(stim[i], 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL word cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && prev_out !== 1'b1) begin
                rises++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL word_edge: unmatched rise at %0d", cyc);
                end else if (exp_q[0] != cyc) begin
                    n_miss++;
                    $display("FAIL word_edge: rise at %0d, expected %0d", cyc, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_out = dout;
        end
        n_vec++;
        if (rises != 420) begin
            n_miss++;
            $display("FAIL word_count: %0d rising edges, expected 420", rises);
        end
    endtask

    task automatic test_words;
        logic [34:0] words [3];
        logic prev_in, prev_out, want;
        words[0] = 35'h5_5AA5_C3F1;
        words[1] = 35'h0_0000_0001;
        words[2] = 35'h7_FFFF_FFFE;
        stim.delete();
        exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            for (int b = 34; b >= 0; b--) push_digit(words[w][b]);
            push_digit(1'b0);
            push_idle(135);
        end
        push_idle(DELAY + DELAY / 2);
        prev_in = 1'b0;
        prev_out = dout;
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i] && !prev_in) exp_q.push_back(cyc + DELAY);
            prev_in = stim[i];
            drive(stim[i], 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL words cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && prev_out !== 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL words_edge: unmatched rise at %0d", cyc);
                end else if (exp_q[0] != cyc) begin
                    n_miss++;
                    $display("FAIL words_edge: rise at %0d, expected %0d", cyc, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            prev_out = dout;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL words_missing: %0d input edges never replayed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_midreset;
        int k0, rise_at, highs, width;
        logic want;
        stim.delete();
        for (int d = 0; d < 3; d++) push_digit(1'b1);
        for (int i = 0; i < 200; i++) begin
            drive(stim[i], 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL midreset_pre cycle %0d: out=%b expected %b", cyc, dout, want);
            end
        end
        for (int i = 200; i < 210; i++) begin
            drive(stim[i], 1'b1);
            n_vec++;
            if (dout !== 1'b0) begin
                n_miss++;
                $display("FAIL midreset_hold cycle %0d: out=%b expected 0", cyc, dout);
            end
        end
        highs = 0;
        for (int i = 0; i < DELAY + 5; i++) begin
            drive(1'b0, 1'b0);
            if (dout === 1'b1) highs++;
        end
        n_vec++;
        if (highs != 0) begin
            n_miss++;
            $display("FAIL midreset_flush: %0d high cycles, expected 0", highs);
        end
        k0 = cyc;
        rise_at = -1;
        width = 0;
        for (int i = 0; i < DELAY + 15; i++) begin
            drive((i < 5) ? 1'b1 : 1'b0, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL midreset_post cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && rise_at < 0) rise_at = cyc;
            if (dout === 1'b1) width++;
        end
        n_vec++;
        if (rise_at != k0 + DELAY || width != 5) begin
            n_miss++;
            $display("FAIL midreset_pulse: rise %0d width %0d, expected %0d 5",
                     rise_at, width, k0 + DELAY);
        end
    endtask

    // The sample driven after edge k lands in ring slot (k + SYNC - r0) mod DEPTH;
    // align the 5-cycle pulse so it occupies slots DEPTH-3 .. 1 across the wrap.
    task automatic test_wrap;
        int k0, rise_at, rises, width, guard;
        logic prev_out, want;
        guard = 0;
        while (((cyc + SYNC - r0) % DEPTH) != DEPTH - 3 && guard < DEPTH + 1) begin
            drive(1'b0, 1'b0);
            guard++;
        end
        n_vec++;
        if (guard > DEPTH) begin
            n_miss++;
            $display("FAIL wrap_align: no alignment within %0d cycles, expected <= %0d", guard, DEPTH);
        end
        k0 = cyc;
        rise_at = -1;
        rises = 0;
        width = 0;
        prev_out = dout;
        for (int i = 0; i < DELAY + 15; i++) begin
            drive((i < 5) ? 1'b1 : 1'b0, 1'b0);
            want = model_out();
            n_vec++;
            if (dout !== want) begin
                n_miss++;
                $display("FAIL wrap cycle %0d: out=%b expected %b", cyc, dout, want);
            end
            if (dout === 1'b1 && prev_out !== 1'b1) begin
                rises++;
                if (rise_at < 0) rise_at = cyc;
            end
            if (dout === 1'b1) width++;
            prev_out = dout;
        end
        n_vec++;
        if (rise_at != k0 + DELAY || rises != 1 || width != 5) begin
            n_miss++;
            $display("FAIL wrap_pulse: rise %0d rises %0d width %0d, expected %0d 1 5",
                     rise_at, rises, width, k0 + DELAY);
        end
    endtask

    initial begin
        test_reset();
        test_const_high();
        test_stale();
        test_single_pulse();
        test_word();
        test_words();
        test_midreset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
